// File: rtl/diff_pkg.sv
// -----------------------------------------------------------------------------
// diff_pkg
// Shared constants and types for the differentiator slice.
//   DIFF_DW / DIFF_LAG_AW : default sample width and lag-buffer address width
//   KD_W                  : width of the signed gain Kd
//   SAT_MAX / SAT_MIN     : output saturation bounds (14-bit signed)
//   diff_state_e          : FILL / RUN sequencing state
// -----------------------------------------------------------------------------
package diff_pkg;

   localparam int DIFF_DW     = 14;
   localparam int DIFF_LAG_AW = 5;
   localparam int KD_W        = 14;
   localparam int DSR_W       = 4;

   localparam int SAT_MAX = 8191;
   localparam int SAT_MIN = -8192;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } diff_state_e;

endpackage : diff_pkg

// File: rtl/diff_delay_line.sv
// -----------------------------------------------------------------------------
// diff_delay_line
// Circular register buffer providing x[n-L] for the differentiator.
// Owns the write pointer; read address is (wp - L) mod depth with L = lag+1.
// The read is combinational and sees the contents before this cycle's write,
// so L equal to the full depth returns the slot about to be overwritten.
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset (clears the write pointer only)
//   we     : write enable, advances the write pointer
//   wdata  : sample to store
//   lag    : lag code, L = lag + 1
//   rdata  : sample written L accepted writes ago
//   wp     : current write pointer
// -----------------------------------------------------------------------------
module diff_delay_line
   import diff_pkg::*;
#(
   parameter int DW     = DIFF_DW,
   parameter int LAG_AW = DIFF_LAG_AW
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     we,
   input  logic signed [DW-1:0]     wdata,
   input  logic        [LAG_AW-1:0] lag,
   output logic signed [DW-1:0]     rdata,
   output logic        [LAG_AW-1:0] wp
);

   localparam int DEPTH = 2 ** LAG_AW;

   logic signed [DW-1:0]     r_mem [0:DEPTH-1];
   logic        [LAG_AW-1:0] r_wp;
   logic        [LAG_AW-1:0] w_raddr;

   // Subtracting lag+1 in LAG_AW bits wraps naturally modulo the depth.
   assign w_raddr = r_wp - lag - LAG_AW'(1);
   assign rdata   = r_mem[w_raddr];
   assign wp      = r_wp;

   // Contents are never read before being written, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (we) begin
         r_mem[r_wp] <= wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wp <= '0;
      end else if (we) begin
         r_wp <= r_wp + LAG_AW'(1);
      end
   end

endmodule : diff_delay_line

// File: rtl/differentiator.sv
// -----------------------------------------------------------------------------
// differentiator
// Discrete differentiator: dat_o = sat14(((x[n] - x[n-L]) * Kd) >>> DSR)
// evaluated on strobed samples, L = set_lag_i + 1.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FILL  | buffer holds fewer than L samples; accepted samples only fill
//   RUN   | buffer primed; every accepted sample enters the pipeline
//
// Pipeline (accept edge k): S1 k registers x / x_old, S2 k+1 difference,
// S3 k+2 product, S4 k+3 shift + saturate into dat_o with a val_o pulse.
//
// Ports:
//   clk_i      : clock
//   rstn_i     : asynchronous active-low reset
//   dat_i      : signed input sample (DW)
//   stb_i      : sample strobe
//   set_kd_i   : signed gain Kd (14)
//   DSR        : arithmetic right-shift amount (4)
//   set_lag_i  : lag code, L = set_lag_i + 1 (LAG_AW)
//   diff_rst_i : synchronous clear
//   set_db_i   : deadband threshold (14, unsigned), only with
//                DIFFERENTIATOR_DEADBAND_EN defined
//   dat_o      : signed saturated derivative (DW)
//   val_o      : one-cycle pulse when dat_o updates
//   ready_o    : lag buffer filled
//
// Build option: DIFFERENTIATOR_DEADBAND_EN adds set_db_i; differences whose
// magnitude is <= set_db_i are forced to zero in S2.
// -----------------------------------------------------------------------------
module differentiator
   import diff_pkg::*;
#(
   parameter int DW     = DIFF_DW,
   parameter int LAG_AW = DIFF_LAG_AW
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic signed [DW-1:0]     dat_i,
   input  logic                     stb_i,
   input  logic signed [KD_W-1:0]   set_kd_i,
   input  logic        [DSR_W-1:0]  DSR,
   input  logic        [LAG_AW-1:0] set_lag_i,
   input  logic                     diff_rst_i,
`ifdef DIFFERENTIATOR_DEADBAND_EN
   input  logic        [KD_W-1:0]   set_db_i,
`endif
   output logic signed [DW-1:0]     dat_o,
   output logic                     val_o,
   output logic                     ready_o
);

   localparam int CNT_W  = LAG_AW + 1;
   localparam int DIFF_W = DW + 1;
   localparam int PROD_W = DIFF_W + KD_W;

   localparam logic signed [PROD_W-1:0] P_SAT_MAX = PROD_W'(SAT_MAX);
   localparam logic signed [PROD_W-1:0] P_SAT_MIN = PROD_W'(SAT_MIN);

   diff_state_e              r_state, w_state_nxt;
   logic        [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic                     r_ready, w_ready_nxt;
   logic        [LAG_AW-1:0] r_lag_prev;

   logic                     w_clr;
   logic                     w_accept;
   logic                     w_s1_load;
   logic        [CNT_W-1:0]  w_lag_len;
   logic        [CNT_W-1:0]  w_cnt_inc;

   logic signed [DW-1:0]     w_rdata;
   logic        [LAG_AW-1:0] w_unused_wp;

   logic                     r_v1, r_v2, r_v3;
   logic signed [DW-1:0]     r_x, r_xold;
   logic signed [DIFF_W-1:0] r_diff;
   logic signed [PROD_W-1:0] r_prod;

   logic signed [DIFF_W-1:0] w_diff_raw;
   logic signed [DIFF_W-1:0] w_diff;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [PROD_W-1:0] w_shift;
   logic signed [DW-1:0]     w_sat;

   // A lag change clears exactly like diff_rst_i, on the first edge where the
   // new value differs from the one captured on the previous edge.
   assign w_clr     = diff_rst_i | (set_lag_i != r_lag_prev);
   assign w_accept  = stb_i & ~w_clr;
   assign w_lag_len = CNT_W'(set_lag_i) + CNT_W'(1);
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_lag_prev <= '0;
      end else begin
         r_lag_prev <= set_lag_i;
      end
   end

   diff_delay_line #(
      .DW     (DW),
      .LAG_AW (LAG_AW)
   ) u_delay_line (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .we     (w_accept),
      .wdata  (dat_i),
      .lag    (set_lag_i),
      .rdata  (w_rdata),
      .wp     (w_unused_wp)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= FILL;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready_nxt = r_ready;
      w_s1_load   = 1'b0;
      if (w_clr) begin
         w_state_nxt = FILL;
         w_cnt_nxt   = '0;
         w_ready_nxt = 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (stb_i) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == w_lag_len) begin
                     w_state_nxt = RUN;
                     w_ready_nxt = 1'b1;
                  end
               end
            end
            RUN: begin
               w_s1_load = stb_i;
            end
            default: begin
               w_state_nxt = FILL;
               w_cnt_nxt   = '0;
               w_ready_nxt = 1'b0;
            end
         endcase
      end
   end

   assign ready_o = r_ready;

   // S2 difference: one extra bit keeps it exact.
   assign w_diff_raw = DIFF_W'(r_x) - DIFF_W'(r_xold);

`ifdef DIFFERENTIATOR_DEADBAND_EN
   logic [DIFF_W-1:0] w_diff_mag;
   assign w_diff_mag = w_diff_raw[DIFF_W-1] ? DIFF_W'(-w_diff_raw) : DIFF_W'(w_diff_raw);
   assign w_diff     = (w_diff_mag <= DIFF_W'(set_db_i)) ? '0 : w_diff_raw;
`else
   assign w_diff = w_diff_raw;
`endif

   // Kd and DSR are applied live in S3/S4, so a gain change reaches samples
   // already in flight without flushing the pipeline.
   assign w_prod  = PROD_W'(r_diff) * PROD_W'(set_kd_i);
   assign w_shift = r_prod >>> DSR;

   always_comb begin
      w_sat = w_shift[DW-1:0];
      if (w_shift > P_SAT_MAX) begin
         w_sat = DW'(SAT_MAX);
      end else if (w_shift < P_SAT_MIN) begin
         w_sat = DW'(SAT_MIN);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         r_x    <= '0;
         r_xold <= '0;
         r_diff <= '0;
         r_prod <= '0;
         dat_o  <= '0;
         val_o  <= 1'b0;
      end else if (w_clr) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         dat_o <= '0;
         val_o <= 1'b0;
      end else begin
         r_v1 <= w_s1_load;
         if (w_s1_load) begin
            r_x    <= dat_i;
            r_xold <= w_rdata;
         end
         r_v2 <= r_v1;
         if (r_v1) begin
            r_diff <= w_diff;
         end
         r_v3 <= r_v2;
         if (r_v2) begin
            r_prod <= w_prod;
         end
         val_o <= r_v3;
         if (r_v3) begin
            dat_o <= w_sat;
         end
      end
   end

endmodule : differentiator

// File: tb/tb_differentiator.sv
// -----------------------------------------------------------------------------
// tb_differentiator
// Directed and randomized stimulus for differentiator, checked every cycle
// against a behavioural model that keeps the sample history since the last
// clear and schedules each result three clocks after its accepting edge.
// -----------------------------------------------------------------------------
module tb_differentiator;

   logic               clk_i = 1'b0;
   logic               rstn_i;
   logic signed [13:0] dat_i;
   logic               stb_i;
   logic signed [13:0] set_kd_i;
   logic        [3:0]  DSR;
   logic        [4:0]  set_lag_i;
   logic               diff_rst_i;
`ifdef DIFFERENTIATOR_DEADBAND_EN
   logic        [13:0] set_db_i;
   int                 db;
`endif
   logic signed [13:0] dat_o;
   logic               val_o;
   logic               ready_o;

   always #5 clk_i = ~clk_i;

   differentiator dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .dat_i      (dat_i),
      .stb_i      (stb_i),
      .set_kd_i   (set_kd_i),
      .DSR        (DSR),
      .set_lag_i  (set_lag_i),
      .diff_rst_i (diff_rst_i),
`ifdef DIFFERENTIATOR_DEADBAND_EN
      .set_db_i   (set_db_i),
`endif
      .dat_o      (dat_o),
      .val_o      (val_o),
      .ready_o    (ready_o)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model state
   int hist[$];
   int due_q[$];
   int res_q[$];
   int cyc = 0;
   int m_dat;
   bit m_val;
   bit m_rdy;
   int m_prev_lag;

   function automatic int sat14(input int v);
      if (v > 8191)  return 8191;
      if (v < -8192) return -8192;
      return v;
   endfunction

   function automatic int calc(input int xn, input int xo);
      int d;
      d = xn - xo;
`ifdef DIFFERENTIATOR_DEADBAND_EN
      if (((d < 0) ? -d : d) <= db) d = 0;
`endif
      return sat14((d * int'(set_kd_i)) >>> int'(DSR));
   endfunction

   task automatic model_edge();
      int  lag_len;
      bit  clr;
      cyc++;
      clr = diff_rst_i || (int'(set_lag_i) != m_prev_lag);
      m_prev_lag = int'(set_lag_i);
      if (clr) begin
         hist.delete();
         due_q.delete();
         res_q.delete();
         m_dat = 0;
         m_val = 0;
         m_rdy = 0;
      end else begin
         m_val = 0;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            m_dat = res_q.pop_front();
            void'(due_q.pop_front());
            m_val = 1;
         end
         if (stb_i) begin
            lag_len = int'(set_lag_i) + 1;
            hist.push_back(int'(dat_i));
            if (hist.size() > lag_len) begin
               res_q.push_back(calc(hist[hist.size()-1], hist[hist.size()-1-lag_len]));
               due_q.push_back(cyc + 3);
            end
            if (hist.size() >= lag_len) m_rdy = 1;
            if (hist.size() > 40) void'(hist.pop_front());
         end
      end
   endtask

   task automatic expect_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_model();
      expect_eq("val_o",   val_o,           m_val);
      expect_eq("ready_o", ready_o,         m_rdy);
      expect_eq("dat_o",   $signed(dat_o),  m_dat);
   endtask

   // Inputs change on the falling edge; outputs are checked on the next one.
   task automatic step(input bit s, input int x);
      stb_i = s;
      dat_i = x[13:0];
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      check_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0);
   endtask

   int x;

   initial begin
      rstn_i     = 1'b0;
      stb_i      = 1'b0;
      dat_i      = '0;
      diff_rst_i = 1'b0;
      set_kd_i   = 14'sd1;
      DSR        = 4'd0;
      set_lag_i  = 5'd3;
`ifdef DIFFERENTIATOR_DEADBAND_EN
      db       = 0;
      set_db_i = '0;
`endif
      m_prev_lag = 3;
      m_dat = 0;
      m_val = 0;
      m_rdy = 0;

      repeat (3) @(negedge clk_i);
      expect_eq("reset_dat",   $signed(dat_o), 0);
      expect_eq("reset_val",   val_o,          0);
      expect_eq("reset_ready", ready_o,        0);
      rstn_i = 1'b1;
      idle(2);

      // fill with L=4
      x = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, x);
         x += 10;
      end
      expect_eq("fill3_ready", ready_o, 0);
      step(1'b1, x); x += 10;
      expect_eq("fill4_ready", ready_o, 1);
      step(1'b1, x); x += 10;
      idle(2);
      expect_eq("lat_early_val", val_o, 0);
      idle(1);
      expect_eq("lat_val", val_o, 1);
      expect_eq("lat_dat", $signed(dat_o), 40);

      // ramp +10, Kd=1 then Kd=-3
      for (int i = 0; i < 12; i++) begin
         step(1'b1, x);
         x += 10;
      end
      idle(4);
      expect_eq("ramp_kd1", $signed(dat_o), 40);
      set_kd_i = -14'sd3;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, x);
         x += 10;
      end
      idle(4);
      expect_eq("ramp_kdm3", $signed(dat_o), -120);

      // saturation steps, L=1
      set_lag_i = 5'd0;
      set_kd_i  = 14'sd8191;
      idle(1);
      step(1'b1, -8192);
      step(1'b1, 8191);
      idle(4);
      expect_eq("sat_pos", $signed(dat_o), 8191);
      step(1'b1, -8192);
      idle(4);
      expect_eq("sat_neg", $signed(dat_o), -8192);

      // shift, L=1
      set_kd_i = 14'sd100;
      DSR      = 4'd3;
      for (int i = 0; i < 5; i++) step(1'b1, i);
      idle(4);
      expect_eq("shift_pos", $signed(dat_o), 12);
      for (int i = 0; i < 5; i++) step(1'b1, 4 - i - 1);
      idle(4);
      expect_eq("shift_neg", $signed(dat_o), -13);

      // diff_rst_i mid-stream with a simultaneous strobe
      set_lag_i = 5'd3;
      set_kd_i  = 14'sd1;
      DSR       = 4'd0;
      idle(1);
      x = 100;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, x);
         x += 10;
      end
      diff_rst_i = 1'b1;
      step(1'b1, x);
      diff_rst_i = 1'b0;
      x += 10;
      expect_eq("clr_dat",   $signed(dat_o), 0);
      expect_eq("clr_ready", ready_o,        0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, x);
         x += 10;
      end
      expect_eq("refill3_ready", ready_o, 0);
      step(1'b1, x); x += 10;
      expect_eq("refill4_ready", ready_o, 1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, x);
         x += 10;
      end

      // lag change 3 -> 7 mid-stream
      set_lag_i = 5'd7;
      step(1'b1, x); x += 10;
      expect_eq("lagchg_dat",   $signed(dat_o), 0);
      expect_eq("lagchg_ready", ready_o,        0);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, x);
         x += 10;
      end
      expect_eq("lag8_fill7_ready", ready_o, 0);
      step(1'b1, x); x += 10;
      expect_eq("lag8_fill8_ready", ready_o, 1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, x);
         x += 10;
      end
      idle(4);
      expect_eq("lag8_dat", $signed(dat_o), 80);

      // L=32 with write-pointer wrap
      set_lag_i = 5'd31;
      idle(1);
      x = 0;
      for (int i = 0; i < 80; i++) begin
         step(1'b1, x);
         x += 1;
      end
      idle(4);
      expect_eq("lag32_dat", $signed(dat_o), 32);
`ifdef DIFFERENTIATOR_DEADBAND_EN
      db       = 40;
      set_db_i = 14'd40;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, x);
         x += 1;
      end
      idle(4);
      expect_eq("deadband_dat", $signed(dat_o), 0);
`endif

      // randomized segments; gain/shift change only while drained
      for (int seg = 0; seg < 8; seg++) begin
         idle(4);
         set_lag_i = 5'($urandom_range(0, 31));
         set_kd_i  = 14'($urandom);
         DSR       = 4'($urandom);
`ifdef DIFFERENTIATOR_DEADBAND_EN
         db       = int'($urandom_range(0, 300));
         set_db_i = 14'(db);
`endif
         for (int i = 0; i < 100; i++) begin
            diff_rst_i = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 16383)) - 8192);
         end
         diff_rst_i = 1'b0;
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_differentiator
